multicycle_controller: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, with a ready handshake to the memory.
- Drives the same datapath select and enable controls as the single-cycle decoder, plus PC/IR write enables.
- Adds a retired-instruction counter and sticky illegal-opcode detection.
- Sits between the shared memory / instruction register and the multi-cycle datapath.

---
 rtl/mips_ctrl_pkg.sv | 82 ++++++++
 rtl/multicycle_controller_if.sv | 43 ++++
 rtl/alu_ctrl_decode.sv | 52 +++++
 rtl/multicycle_controller.sv | 169 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS control path: opcodes, funct codes,
// ALU operation codes, controller states and PC source selects.
package mips_ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU operation codes, same order as the single-cycle decoder
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_SRA   = 5'd4;
    localparam logic [4:0] ALU_SRL   = 5'd5;
    localparam logic [4:0] ALU_SLL   = 5'd6;
    localparam logic [4:0] ALU_SLLV  = 5'd7;
    localparam logic [4:0] ALU_SLT   = 5'd8;
    localparam logic [4:0] ALU_ADDI  = 5'd9;
    localparam logic [4:0] ALU_ADDIU = 5'd10;
    localparam logic [4:0] ALU_ANDI  = 5'd11;
    localparam logic [4:0] ALU_ORI   = 5'd12;
    localparam logic [4:0] ALU_LUI   = 5'd13;
    localparam logic [4:0] ALU_SLTIU = 5'd14;
    localparam logic [4:0] ALU_SLTI  = 5'd15;
    localparam logic [4:0] ALU_BEQ   = 5'd16;
    localparam logic [4:0] ALU_BNE   = 5'd17;
    localparam logic [4:0] ALU_LW    = 5'd18;
    localparam logic [4:0] ALU_SW    = 5'd19;

    // PC source selects
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC    = 4'd2,
        ST_WB      = 4'd3,
        ST_ADDR    = 4'd4,
        ST_MEM     = 4'd5,
        ST_LDWB    = 4'd6,
        ST_BRANCH  = 4'd7,
        ST_JUMP    = 4'd8,
        ST_ILLEGAL = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ALUI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_BNE,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_class_e;

endpackage

// File: rtl/multicycle_controller_if.sv
// Bus between the multi-cycle controller and the IR / memory / datapath.
// Handshake: a memory strobe (mem_read in FETCH, mem_read/mem_write in MEM)
// stays asserted until the cycle in which mem_ready is high; that cycle
// completes the access. mem_ready has no effect in any other state.
interface multicycle_controller_if #(
    parameter int ALUCTR_W = 5,
    parameter int RETIRE_W = 32
);
    logic [5:0]          op_code;
    logic [5:0]          f_code;
    logic                mem_ready;
    logic                alu_zero;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic [ALUCTR_W-1:0] alu_ctr;
    logic                alu_mux1;
    logic                alu_mux2;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                sel_reg;
    logic                mem_to_reg;
    logic                illegal;
    logic [RETIRE_W-1:0] retired;
    logic [3:0]          state;

    // Controller side
    modport master (
        input  op_code, f_code, mem_ready, alu_zero,
        output ir_write, pc_write, pc_src, alu_ctr, alu_mux1, alu_mux2,
               reg_write, mem_read, mem_write, sel_reg, mem_to_reg,
               illegal, retired, state
    );

    // Memory / datapath side
    modport slave (
        output op_code, f_code, mem_ready, alu_zero,
        input  ir_write, pc_write, pc_src, alu_ctr, alu_mux1, alu_mux2,
               reg_write, mem_read, mem_write, sel_reg, mem_to_reg,
               illegal, retired, state
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder shared with the single-cycle path:
// (op, funct) -> ALU code, operand selects and instruction class.
module alu_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   op_i,
    input  logic [5:0]   f_i,
    output logic [4:0]   alu_code_o,
    output logic         alu_mux1_o,
    output logic         alu_mux2_o,
    output instr_class_e cls_o
);

    // Table lookup; anything unrecognised is classed illegal with zero controls
    always_comb begin
        alu_code_o = ALU_ADD;
        alu_mux1_o = 1'b0;
        alu_mux2_o = 1'b0;
        cls_o      = CLS_ILLEGAL;
        case (op_i)
            OP_RTYPE: begin
                cls_o = CLS_RTYPE;
                case (f_i)
                    FN_ADD:  alu_code_o = ALU_ADD;
                    FN_SUB:  alu_code_o = ALU_SUB;
                    FN_AND:  alu_code_o = ALU_AND;
                    FN_OR:   alu_code_o = ALU_OR;
                    FN_SRA:  begin alu_code_o = ALU_SRA; alu_mux1_o = 1'b1; end
                    FN_SRL:  begin alu_code_o = ALU_SRL; alu_mux1_o = 1'b1; end
                    FN_SLL:  begin alu_code_o = ALU_SLL; alu_mux1_o = 1'b1; end
                    FN_SLLV: alu_code_o = ALU_SLLV;
                    FN_SLT:  alu_code_o = ALU_SLT;
                    default: cls_o = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI:  begin cls_o = CLS_ALUI;  alu_code_o = ALU_ADDI;  alu_mux2_o = 1'b1; end
            OP_ADDIU: begin cls_o = CLS_ALUI;  alu_code_o = ALU_ADDIU; alu_mux2_o = 1'b1; end
            OP_ANDI:  begin cls_o = CLS_ALUI;  alu_code_o = ALU_ANDI;  alu_mux2_o = 1'b1; end
            OP_ORI:   begin cls_o = CLS_ALUI;  alu_code_o = ALU_ORI;   alu_mux2_o = 1'b1; end
            OP_LUI:   begin cls_o = CLS_ALUI;  alu_code_o = ALU_LUI;   alu_mux2_o = 1'b1; end
            OP_SLTIU: begin cls_o = CLS_ALUI;  alu_code_o = ALU_SLTIU; alu_mux2_o = 1'b1; end
            OP_SLTI:  begin cls_o = CLS_ALUI;  alu_code_o = ALU_SLTI;  alu_mux2_o = 1'b1; end
            OP_LW:    begin cls_o = CLS_LOAD;  alu_code_o = ALU_LW;    alu_mux2_o = 1'b1; end
            OP_SW:    begin cls_o = CLS_STORE; alu_code_o = ALU_SW;    alu_mux2_o = 1'b1; end
            OP_BEQ:   begin cls_o = CLS_BEQ;   alu_code_o = ALU_BEQ;   end
            OP_BNE:   begin cls_o = CLS_BNE;   alu_code_o = ALU_BNE;   end
            OP_J:     cls_o = CLS_JUMP;
            default:  cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS controller: sequences each instruction through
// fetch/decode/execute/memory/writeback, counts retired instructions and
// parks in a sticky illegal state on unsupported encodings.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTR_W = 5,
    parameter int RETIRE_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    state_e              state_q;
    logic [5:0]          op_q;
    logic [5:0]          f_q;
    logic                illegal_q;
    logic [RETIRE_W-1:0] retired_q;

    logic [5:0]   dec_op;
    logic [5:0]   dec_f;
    logic [4:0]   dec_code;
    logic         dec_mux1;
    logic         dec_mux2;
    instr_class_e dec_cls;

    // DECODE classifies the live IR fields; every later state uses the latched copy
    assign dec_op = (state_q == ST_DECODE) ? bus.op_code : op_q;
    assign dec_f  = (state_q == ST_DECODE) ? bus.f_code  : f_q;

    alu_ctrl_decode u_decode (
        .op_i       (dec_op),
        .f_i        (dec_f),
        .alu_code_o (dec_code),
        .alu_mux1_o (dec_mux1),
        .alu_mux2_o (dec_mux2),
        .cls_o      (dec_cls)
    );

    // Sequencer: state, latched opcode fields, sticky illegal flag and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            f_q       <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH: if (bus.mem_ready) state_q <= ST_DECODE;
                ST_DECODE: begin
                    op_q <= bus.op_code;
                    f_q  <= bus.f_code;
                    case (dec_cls)
                        CLS_RTYPE, CLS_ALUI: state_q <= ST_EXEC;
                        CLS_LOAD, CLS_STORE: state_q <= ST_ADDR;
                        CLS_BEQ, CLS_BNE:    state_q <= ST_BRANCH;
                        CLS_JUMP:            state_q <= ST_JUMP;
                        default: begin
                            state_q   <= ST_ILLEGAL;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                ST_EXEC: state_q <= ST_WB;
                ST_ADDR: state_q <= ST_MEM;
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        if (dec_cls == CLS_LOAD) begin
                            state_q <= ST_LDWB;
                        end else begin
                            state_q   <= ST_FETCH;
                            retired_q <= retired_q + RETIRE_W'(1);
                        end
                    end
                end
                ST_WB, ST_LDWB, ST_BRANCH, ST_JUMP: begin
                    state_q   <= ST_FETCH;
                    retired_q <= retired_q + RETIRE_W'(1);
                end
                ST_ILLEGAL: state_q <= ST_ILLEGAL;
                default:    state_q <= ST_FETCH;
            endcase
        end
    end

    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [4:0] alu_code;
    logic       alu_mux1;
    logic       alu_mux2;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       sel_reg;
    logic       mem_to_reg;

    // Per-state datapath controls; everything is forced low while reset is held
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_SEQ;
        alu_code   = 5'd0;
        alu_mux1   = 1'b0;
        alu_mux2   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        sel_reg    = 1'b0;
        mem_to_reg = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = bus.mem_ready;
                    pc_write = bus.mem_ready;
                end
                ST_EXEC, ST_WB: begin
                    alu_code  = dec_code;
                    alu_mux1  = dec_mux1;
                    alu_mux2  = dec_mux2;
                    reg_write = (state_q == ST_WB);
                    sel_reg   = (state_q == ST_WB) && (dec_cls == CLS_RTYPE);
                end
                ST_ADDR: begin
                    alu_code = dec_code;
                    alu_mux2 = 1'b1;
                end
                ST_MEM: begin
                    mem_read  = (dec_cls == CLS_LOAD);
                    mem_write = (dec_cls == CLS_STORE);
                end
                ST_LDWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_BRANCH: begin
                    alu_code = dec_code;
                    pc_src   = PCSRC_BRANCH;
                    pc_write = ((dec_cls == CLS_BEQ) &&  bus.alu_zero) ||
                               ((dec_cls == CLS_BNE) && !bus.alu_zero);
                end
                ST_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.alu_ctr    = ALUCTR_W'(alu_code);
    assign bus.alu_mux1   = alu_mux1;
    assign bus.alu_mux2   = alu_mux2;
    assign bus.reg_write  = reg_write;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.sel_reg    = sel_reg;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.illegal    = illegal_q;
    assign bus.retired    = retired_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction sequences, a
// cycle-schedule model per instruction class, and literal pin-down checks.
module tb_multicycle_controller;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_J = 6, K_ILL = 7;

    typedef struct packed {
        logic [3:0]  state;
        logic        ir_write;
        logic        pc_write;
        logic [1:0]  pc_src;
        logic [5:0]  alu_ctr;
        logic        alu_mux1;
        logic        alu_mux2;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        sel_reg;
        logic        mem_to_reg;
        logic        illegal;
        logic [31:0] retired;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op_code = '0;
    logic [5:0] f_code = '0;
    logic       mem_ready = 1'b0;
    logic       alu_zero = 1'b0;

    int          test_cnt = 0;
    int          fail_cnt = 0;
    exp_t        exp_q[$];
    logic [31:0] model_retired = '0;
    logic        ill_flag = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    multicycle_controller_if #(.ALUCTR_W(6), .RETIRE_W(32)) bus ();
    multicycle_controller_if #(.ALUCTR_W(5), .RETIRE_W(4))  b4 ();

    assign bus.op_code   = op_code;
    assign bus.f_code    = f_code;
    assign bus.mem_ready = mem_ready;
    assign bus.alu_zero  = alu_zero;
    assign b4.op_code    = op_code;
    assign b4.f_code     = f_code;
    assign b4.mem_ready  = mem_ready;
    assign b4.alu_zero   = alu_zero;

    multicycle_controller #(.ALUCTR_W(6), .RETIRE_W(32)) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    multicycle_controller #(.ALUCTR_W(5), .RETIRE_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .bus(b4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t sample();
        exp_t o;
        o.state      = bus.state;
        o.ir_write   = bus.ir_write;
        o.pc_write   = bus.pc_write;
        o.pc_src     = bus.pc_src;
        o.alu_ctr    = bus.alu_ctr;
        o.alu_mux1   = bus.alu_mux1;
        o.alu_mux2   = bus.alu_mux2;
        o.reg_write  = bus.reg_write;
        o.mem_read   = bus.mem_read;
        o.mem_write  = bus.mem_write;
        o.sel_reg    = bus.sel_reg;
        o.mem_to_reg = bus.mem_to_reg;
        o.illegal    = bus.illegal;
        o.retired    = bus.retired;
        return o;
    endfunction

    // scoreboard: one expected record per driven cycle, checked mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t o;
            e = exp_q.pop_front();
            o = sample();
            check($sformatf("cycle st%0d", e.state), 64'(o), 64'(e));
            check("retired4", 64'(b4.retired), 64'(e.retired[3:0]));
        end
    end

    // instruction table: class, ALU code and operand selects
    function automatic void info(input logic [5:0] op, input logic [5:0] f, output int kind,
                                 output logic [5:0] code, output logic m1, output logic m2);
        kind = K_ILL; code = '0; m1 = 1'b0; m2 = 1'b0;
        case (op)
            6'h00: begin
                kind = K_R;
                case (f)
                    6'h20: code = 6'd0;
                    6'h22: code = 6'd1;
                    6'h24: code = 6'd2;
                    6'h25: code = 6'd3;
                    6'h03: begin code = 6'd4; m1 = 1'b1; end
                    6'h02: begin code = 6'd5; m1 = 1'b1; end
                    6'h00: begin code = 6'd6; m1 = 1'b1; end
                    6'h04: code = 6'd7;
                    6'h2A: code = 6'd8;
                    default: kind = K_ILL;
                endcase
            end
            6'h08: begin kind = K_I; code = 6'd9;  m2 = 1'b1; end
            6'h09: begin kind = K_I; code = 6'd10; m2 = 1'b1; end
            6'h0C: begin kind = K_I; code = 6'd11; m2 = 1'b1; end
            6'h0D: begin kind = K_I; code = 6'd12; m2 = 1'b1; end
            6'h0F: begin kind = K_I; code = 6'd13; m2 = 1'b1; end
            6'h0B: begin kind = K_I; code = 6'd14; m2 = 1'b1; end
            6'h0A: begin kind = K_I; code = 6'd15; m2 = 1'b1; end
            6'h04: begin kind = K_BEQ; code = 6'd16; end
            6'h05: begin kind = K_BNE; code = 6'd17; end
            6'h23: begin kind = K_LW; code = 6'd18; end
            6'h2B: begin kind = K_SW; code = 6'd19; end
            6'h02: kind = K_J;
            default: kind = K_ILL;
        endcase
    endfunction

    function automatic exp_t base(input logic [3:0] s);
        exp_t e;
        e = '0;
        e.state   = s;
        e.retired = model_retired;
        e.illegal = ill_flag;
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    // driver: one cycle of inputs plus its expected outputs
    task automatic step(input exp_t e, input logic mr, input logic az, input logic [5:0] op,
                        input logic [5:0] f, output exp_t o);
        @(posedge clk); #1;
        mem_ready = mr; alu_zero = az; op_code = op; f_code = f;
        exp_q.push_back(e);
        @(negedge clk); #1;
        o = sample();
    endtask

    task automatic fetch_wait();
        exp_t e;
        exp_t o;
        e = base(4'd0);
        e.mem_read = 1'b1;
        step(e, 1'b0, rbit(), rop(), rop(), o);
    endtask

    task automatic apply_reset();
        reset = 1'b1; mem_ready = 1'b0;
        model_retired = '0; ill_flag = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        reset = 1'b0;
    endtask

    // driver: a whole instruction with fw fetch waits and mw memory waits
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic az,
                             input int fw, input int mw, input int ill_n, input bit stop_mem,
                             output int ncyc, output int mr_cnt, output exp_t key);
        int kind;
        logic [5:0] code;
        logic m1, m2;
        exp_t e, o;
        info(op, f, kind, code, m1, m2);
        ncyc = 0; mr_cnt = 0;
        for (int i = 0; i <= fw; i++) begin
            e = base(4'd0);
            e.mem_read = 1'b1;
            if (i == fw) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
            step(e, (i == fw), rbit(), rop(), rop(), o); ncyc++;
        end
        step(base(4'd1), rbit(), rbit(), op, f, o); ncyc++;
        case (kind)
            K_R, K_I: begin
                e = base(4'd2);
                e.alu_ctr = code; e.alu_mux1 = m1; e.alu_mux2 = m2;
                step(e, rbit(), rbit(), rop(), rop(), o); ncyc++;
                e.state = 4'd3; e.reg_write = 1'b1; e.sel_reg = (kind == K_R);
                step(e, rbit(), rbit(), rop(), rop(), o); ncyc++;
                model_retired++;
            end
            K_LW, K_SW: begin
                e = base(4'd4);
                e.alu_ctr = code; e.alu_mux2 = 1'b1;
                step(e, rbit(), rbit(), rop(), rop(), o); ncyc++;
                for (int i = 0; i <= mw; i++) begin
                    e = base(4'd5);
                    e.mem_read = (kind == K_LW); e.mem_write = (kind == K_SW);
                    step(e, (i == mw), rbit(), rop(), rop(), o); ncyc++;
                    if (o.mem_read) mr_cnt++;
                    if (stop_mem) begin key = o; return; end
                end
                if (kind == K_SW) begin
                    model_retired++;
                end else begin
                    e = base(4'd6);
                    e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                    step(e, rbit(), rbit(), rop(), rop(), o); ncyc++;
                    model_retired++;
                end
            end
            K_BEQ, K_BNE: begin
                e = base(4'd7);
                e.alu_ctr = code; e.pc_src = 2'b01;
                e.pc_write = (kind == K_BEQ) ? az : ~az;
                step(e, rbit(), az, rop(), rop(), o); ncyc++;
                model_retired++;
            end
            K_J: begin
                e = base(4'd8);
                e.pc_write = 1'b1; e.pc_src = 2'b10;
                step(e, rbit(), rbit(), rop(), rop(), o); ncyc++;
                model_retired++;
            end
            default: begin
                ill_flag = 1'b1;
                for (int i = 0; i < ill_n; i++) begin
                    step(base(4'd9), rbit(), rbit(), rop(), rop(), o); ncyc++;
                end
            end
        endcase
        key = o;
    endtask

    logic [5:0] tbl_op[15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h0B, 6'h0A};
    logic [5:0] tbl_f[15]  = '{6'h22, 6'h24, 6'h25, 6'h03, 6'h02, 6'h00, 6'h04, 6'h2A,
                               6'h20, 6'h11, 6'h3F, 6'h00, 6'h2A, 6'h05, 6'h24};

    initial begin
        int n, mc;
        exp_t k;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_retired", 64'(bus.retired), 64'd0);
        check("rst_strobes", 64'({bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write}), 64'd0);
        check("rst_illegal", 64'(bus.illegal), 64'd0);
        mem_ready = 1'b0;
        reset = 1'b0;

        // ADD with mem_ready high
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, 0, 1'b0, n, mc, k);
        check("add_cycles", 64'(n), 64'd4);
        check("add_wb", 64'({k.state, k.reg_write, k.sel_reg, k.alu_ctr}), 64'({4'd3, 2'b11, 6'd0}));
        fetch_wait();
        check("add_retired", 64'(bus.retired), 64'd1);

        // remaining R-type and ALU-immediate ops
        for (int i = 0; i < 15; i++) begin
            run_instr(tbl_op[i], tbl_f[i], 1'b0, i % 3, 0, 0, 1'b0, n, mc, k);
            if (i == 3) check("sra_wb", 64'({k.alu_mux1, k.alu_mux2, k.alu_ctr}), 64'({2'b10, 6'd4}));
            if (i == 12) check("lui_wb", 64'({k.alu_mux1, k.alu_mux2, k.sel_reg, k.alu_ctr}), 64'({3'b010, 6'd13}));
        end

        // LW with two memory wait cycles
        run_instr(6'h23, 6'h00, 1'b0, 0, 2, 0, 1'b0, n, mc, k);
        check("lw_cycles", 64'(n), 64'd7);
        check("lw_mem_read_cycles", 64'(mc), 64'd3);
        check("lw_ldwb", 64'({k.state, k.reg_write, k.mem_to_reg, k.sel_reg}), 64'({4'd6, 3'b110}));

        // SW
        run_instr(6'h2B, 6'h00, 1'b0, 0, 0, 0, 1'b0, n, mc, k);
        check("sw_cycles", 64'(n), 64'd4);
        run_instr(6'h2B, 6'h00, 1'b0, 1, 1, 0, 1'b0, n, mc, k);
        check("sw_wait_cycles", 64'(n), 64'd6);

        // branches
        run_instr(6'h04, 6'h00, 1'b1, 0, 0, 0, 1'b0, n, mc, k);
        check("beq_taken", 64'({k.pc_write, k.pc_src}), 64'(3'b101));
        check("beq_cycles", 64'(n), 64'd3);
        fetch_wait();
        check("beq_retired", 64'(bus.retired), 64'd20);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0, 0, 1'b0, n, mc, k);
        check("beq_not_taken", 64'({k.pc_write, k.pc_src}), 64'(3'b001));
        run_instr(6'h05, 6'h00, 1'b1, 0, 0, 0, 1'b0, n, mc, k);
        check("bne_not_taken", 64'({k.pc_write, k.pc_src}), 64'(3'b001));
        fetch_wait();
        check("bne_retired", 64'(bus.retired), 64'd22);
        run_instr(6'h05, 6'h00, 1'b0, 0, 0, 0, 1'b0, n, mc, k);
        check("bne_taken", 64'({k.pc_write, k.pc_src}), 64'(3'b101));

        // jump
        run_instr(6'h02, 6'h00, 1'b0, 0, 0, 0, 1'b0, n, mc, k);
        check("j_cycles", 64'(n), 64'd3);
        check("j_ctl", 64'({k.pc_write, k.pc_src, k.reg_write}), 64'(4'b1100));

        // reset in the middle of a stalled SW
        run_instr(6'h2B, 6'h00, 1'b0, 0, 3, 0, 1'b1, n, mc, k);
        check("sw_mem_write", 64'(k.mem_write), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_state", 64'(bus.state), 64'd0);
        check("midrst_mem_write", 64'(bus.mem_write), 64'd0);
        check("midrst_mem_read", 64'(bus.mem_read), 64'd0);
        check("midrst_retired", 64'(bus.retired), 64'd0);
        apply_reset();
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, 0, 1'b0, n, mc, k);
        check("post_rst_add_cycles", 64'(n), 64'd4);

        // counter wrap on the 4-bit instance
        apply_reset();
        for (int i = 0; i < 17; i++) run_instr(6'h00, 6'h20, 1'b0, 0, 0, 0, 1'b0, n, mc, k);
        fetch_wait();
        check("wrap_retired4", 64'(b4.retired), 64'd1);
        check("wrap_retired32", 64'(bus.retired), 64'd17);

        // illegal opcode: sticky, no enables, counter frozen
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 20, 1'b0, n, mc, k);
        check("ill_cycles", 64'(n), 64'd22);
        check("ill_flag", 64'({k.state, k.illegal}), 64'({4'd9, 1'b1}));
        check("ill_enables", 64'({k.reg_write, k.mem_write, k.pc_write, k.ir_write, k.mem_read}), 64'd0);
        check("ill_retired", 64'(bus.retired), 64'd17);
        apply_reset();
        check("ill_cleared", 64'(bus.illegal), 64'd0);

        // unsupported funct is also illegal
        run_instr(6'h00, 6'h08, 1'b0, 0, 0, 5, 1'b0, n, mc, k);
        check("bad_funct", 64'({k.state, k.illegal}), 64'({4'd9, 1'b1}));
        apply_reset();
        run_instr(6'h0D, 6'h00, 1'b0, 2, 0, 0, 1'b0, n, mc, k);
        check("ori_cycles", 64'(n), 64'd6);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
